// File: rtl/sap1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// sap1_controller_sequencer
//
// Controller-sequencer for the SAP-1 computer. A six-state one-hot ring
// counter (T1..T6) is combined with a decode of the opcode nibble from the
// instruction register to produce the 12-bit control word. The word
// sequences PC, MAR, RAM, IR, accumulator, ALU, B and output registers over
// the W bus. The block also owns the halt flag that stops the machine.
//
// Opcode map: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111.
// Any other opcode executes as a NOP (T4..T6 idle).
//
// Ports:
//   CLK       in   system clock, all state changes on the rising edge
//   CLR_bar   in   synchronous active-low reset (returns ring to T1 and
//                  clears the halt flag)
//   instr_in  in   [3:0] opcode from IR upper nibble, used in T4..T6 only
//   Cp        out  PC increment                (active-high)
//   Ep        out  PC drives W bus             (active-high)
//   Lm_bar    out  MAR load                    (active-low)
//   CE_bar    out  RAM drives W bus            (active-low)
//   Li_bar    out  IR load                     (active-low)
//   Ei_bar    out  IR operand drives W bus     (active-low)
//   La_bar    out  accumulator load            (active-low)
//   Ea        out  accumulator drives W bus    (active-high)
//   Su        out  ALU subtract select         (active-high)
//   Eu        out  ALU drives W bus            (active-high)
//   Lb_bar    out  B register load             (active-low)
//   Lo_bar    out  output register load        (active-low)
//   HLT       out  halt indication             (active-high)
//   t_state   out  [5:0] one-hot ring state, bit0=T1 .. bit5=T6
//
// Build option:
//   SAP1_SHORT_CYCLE_EN  when defined, instructions with trailing idle
//                        T-states return to T1 early (LDA after T5, OUT and
//                        undefined opcodes after T4). ADD, SUB and HLT are
//                        unaffected. When undefined, every instruction takes
//                        six states.
// -----------------------------------------------------------------------------
module sap1_controller_sequencer (
    input  logic       CLK,
    input  logic       CLR_bar,
    input  logic [3:0] instr_in,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm_bar,
    output logic       CE_bar,
    output logic       Li_bar,
    output logic       Ei_bar,
    output logic       La_bar,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb_bar,
    output logic       Lo_bar,
    output logic       HLT,
    output logic [5:0] t_state
);

    // One-hot ring states
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // Opcodes
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [5:0] t_state_reg;
    logic [5:0] t_state_next;
    logic       halt_reg;
    logic       halt_next;
    logic [5:0] t_rot;

    // Opcode decode (only meaningful in T4..T6)
    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_out;
    logic is_hlt;
    logic is_defined;

    assign is_lda     = (instr_in == OP_LDA);
    assign is_add     = (instr_in == OP_ADD);
    assign is_sub     = (instr_in == OP_SUB);
    assign is_out     = (instr_in == OP_OUT);
    assign is_hlt     = (instr_in == OP_HLT);
    assign is_defined = is_lda | is_add | is_sub | is_out | is_hlt;

    // Ring rotation: each bit takes the previous one, T6 wraps to T1.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_ring
            assign t_rot[gi] = t_state_reg[(gi + 5) % 6];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        t_state_next = t_state_reg;
        halt_next    = halt_reg;

        if (!halt_reg) begin
            case (t_state_reg)
                T1, T2, T3, T6: begin
                    t_state_next = t_rot;
                end
                T4: begin
                    if (is_hlt) begin
                        // Freeze at T4; only a reset leaves this state.
                        halt_next    = 1'b1;
                        t_state_next = T4;
                    end
`ifdef SAP1_SHORT_CYCLE_EN
                    else if (is_out || !is_defined) begin
                        t_state_next = T1;
                    end
`endif
                    else begin
                        t_state_next = t_rot;
                    end
                end
                T5: begin
`ifdef SAP1_SHORT_CYCLE_EN
                    if (is_lda) begin
                        t_state_next = T1;
                    end else begin
                        t_state_next = t_rot;
                    end
`else
                    t_state_next = t_rot;
`endif
                end
                default: begin
                    // Not one-hot: recover by restarting the fetch.
                    t_state_next = T1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR_bar) begin
            t_state_reg <= T1;
            halt_reg    <= 1'b0;
        end else begin
            t_state_reg <= t_state_next;
            halt_reg    <= halt_next;
        end
    end

    assign t_state = t_state_reg;

    // -------------------------------------------------------------------------
    // Control word decode (Moore on t_state plus opcode)
    // -------------------------------------------------------------------------
    always_comb begin
        Cp     = 1'b0;
        Ep     = 1'b0;
        Lm_bar = 1'b1;
        CE_bar = 1'b1;
        Li_bar = 1'b1;
        Ei_bar = 1'b1;
        La_bar = 1'b1;
        Ea     = 1'b0;
        Su     = 1'b0;
        Eu     = 1'b0;
        Lb_bar = 1'b1;
        Lo_bar = 1'b1;
        HLT    = 1'b0;

        if (halt_reg) begin
            // Halted: every control inactive, only HLT asserted.
            HLT = 1'b1;
        end else begin
            case (t_state_reg)
                // Fetch, common to every opcode
                T1: begin
                    Ep     = 1'b1;
                    Lm_bar = 1'b0;
                end
                T2: begin
                    Cp = 1'b1;
                end
                T3: begin
                    CE_bar = 1'b0;
                    Li_bar = 1'b0;
                end
                // Execute
                T4: begin
                    if (is_lda || is_add || is_sub) begin
                        Ei_bar = 1'b0;
                        Lm_bar = 1'b0;
                    end else if (is_out) begin
                        Ea     = 1'b1;
                        Lo_bar = 1'b0;
                    end else if (is_hlt) begin
                        HLT = 1'b1;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        CE_bar = 1'b0;
                        La_bar = 1'b0;
                    end else if (is_add || is_sub) begin
                        CE_bar = 1'b0;
                        Lb_bar = 1'b0;
                        Su     = is_sub;
                    end
                end
                T6: begin
                    if (is_add || is_sub) begin
                        Eu     = 1'b1;
                        La_bar = 1'b0;
                        Su     = is_sub;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/sap1_controller_sequencer.md
# sap1_controller_sequencer

SAP-1 controller-sequencer. A six-state ring counter (T1–T6) is combined with a decode of the opcode nibble held by the instruction register. Together they drive the 12-bit control word that sequences PC, MAR, RAM, IR, accumulator, ALU, B and output registers over the W bus. The block also owns the halt condition that stops the machine clock.

## Interface
Parameters:
- none (opcode map fixed: LDA=4'b0000, ADD=4'b0001, SUB=4'b0010, OUT=4'b1110, HLT=4'b1111)

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- CLR_bar  in  1  synchronous, active-low reset, sampled on rising CLK
- instr_in  in  4  opcode from instruction register upper nibble; valid T4–T6
- Cp  out  1  PC increment (active-high)
- Ep  out  1  PC drive W bus (active-high)
- Lm_bar  out  1  MAR load (active-low)
- CE_bar  out  1  RAM drive W bus (active-low)
- Li_bar  out  1  IR load (active-low)
- Ei_bar  out  1  IR operand drive W bus (active-low)
- La_bar  out  1  accumulator load (active-low)
- Ea  out  1  accumulator drive W bus (active-high)
- Su  out  1  ALU subtract select (active-high)
- Eu  out  1  ALU drive W bus (active-high)
- Lb_bar  out  1  B register load (active-low)
- Lo_bar  out  1  output register load (active-low)
- HLT  out  1  halt indication, active-high
- t_state  out  6  one-hot ring state, bit0=T1 … bit5=T6

## Operation
- The ring state is a registered one-hot value, t_state. The control word is a Moore decode of t_state and instr_in. Any control not listed below is inactive: active-high signals = 0, active-low signals = 1.
- Fetch, for all opcodes:
  - T1: Ep=1, Lm_bar=0
  - T2: Cp=1
  - T3: CE_bar=0, Li_bar=0
- LDA:
  - T4: Ei_bar=0, Lm_bar=0
  - T5: CE_bar=0, La_bar=0
  - T6: idle
- ADD:
  - T4: Ei_bar=0, Lm_bar=0
  - T5: CE_bar=0, Lb_bar=0
  - T6: Eu=1, La_bar=0
- SUB: same as ADD, with Su=1 during both T5 and T6.
- OUT:
  - T4: Ea=1, Lo_bar=0
  - T5–T6: idle
- HLT:
  - T4: HLT=1, all other controls inactive.
  - On the T4 clock edge the internal halt flag is set. The ring freezes at T4, and HLT stays 1 with all controls inactive until reset.
- Undefined opcodes: T4–T6 idle (NOP).
- Ring advance: T1→T2→…→T6→T1 on every rising edge unless halted or short-cycled (see Configuration).
- Reset (CLR_bar=0 at a rising edge):
  - t_state=6'b000001 and the halt flag is cleared.
  - Outputs in the cycle after reset are the T1 word: Ep=1, Lm_bar=0, all others inactive, HLT=0, t_state=6'b000001.
  - Reset takes priority over halt and over the ring advance, in any state, including mid-instruction.

## Timing
- Control outputs are combinational from registered state. They are valid the same cycle the state is entered and change only after a CLK edge or an instr_in change.
- instr_in is sampled combinationally in T4–T6 only. In T1–T3 it is ignored, because the IR loads at the end of T3.
- Full instruction length: 6 cycles. Throughput is 1 instruction per 6 clocks without short-cycle.
- HLT: asserted from T4 of the HLT instruction, 3 cycles after T1. It is held indefinitely. A state change out of halt requires a CLR_bar pulse sampled on a CLK edge.
- CLR_bar deasserted: the first advance occurs on the next rising edge (T1→T2).
- No two-bus-driver conflict exists: at most one of Ep, CE_bar=0, Ei_bar=0, Ea, Eu is active in any state.

## Configuration
- SAP1_SHORT_CYCLE_EN defined: instructions with trailing idle T-states return early. The next edge goes to T1 instead of the next T-state:
  - LDA: T5→T1 (5 cycles)
  - OUT: T4→T1 (4 cycles)
  - undefined opcode: T4→T1 (4 cycles)
  - ADD, SUB and HLT are unchanged.
- SAP1_SHORT_CYCLE_EN undefined: every instruction takes exactly 6 states, as in Operation.

## Test plan
- Reset: CLR_bar=0 for 2 edges from arbitrary state → t_state=000001, Ep=1, Lm_bar=0, HLT=0, all else inactive.
- LDA (instr_in=0000) over T1–T6 → control words match Operation per state; t_state returns to 000001 after 6 edges (5 with SAP1_SHORT_CYCLE_EN).
- SUB (instr_in=0010) → T5: CE_bar=0, Lb_bar=0, Su=1; T6: Eu=1, La_bar=0, Su=1; exactly one bus driver active per state.
- OUT (instr_in=1110) → T4: Ea=1, Lo_bar=0; next T1 after 6 edges, or after 4 with short-cycle.
- HLT (instr_in=1111) → HLT=1 at T4; t_state stays 001000 for 20 edges with controls inactive; CLR_bar=0 → T1 word, HLT=0.
- Reset mid-instruction: CLR_bar=0 at T5 of ADD → next cycle t_state=000001, La_bar=1, Lb_bar=1.
